// File: rtl/msk_sched_pkg.sv
// Shared sizing and round-robin helpers for the masked Toffoli gadget scheduler.
package msk_sched_pkg;

    function automatic int hpc3_rnd_bits(input int d);
        return d * (d - 1);
    endfunction

    function automatic int tag_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    function automatic int rr_next(input int idx, input int nreq);
        return (idx + 1 >= nreq) ? 0 : idx + 1;
    endfunction

    function automatic int rr_index(input int ptr, input int offset, input int nreq);
        return (ptr + offset) % nreq;
    endfunction

endpackage

// File: rtl/MSKand_hpc3o_tof.sv
// HPC3-style masked a&b^c gadget, d shares, one-cycle latency; the a-share
// product term uses the externally delayed ina_prev. Randomness: [pairs] r, [pairs] r'.
module MSKand_hpc3o_tof #(
    parameter int d = 2
) (
    input  logic                 clk,
    input  logic [d-1:0]         ina,
    input  logic [d-1:0]         inb,
    input  logic [d-1:0]         inc,
    input  logic [d-1:0]         ina_prev,
    input  logic [d*(d-1)-1:0]   rnd,
    output logic [d-1:0]         out
);

    localparam int NPAIR = d * (d - 1) / 2;

    function automatic int pair_idx(input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * d - lo * (lo + 1) / 2 + (hi - lo - 1);
    endfunction

    logic [d-1:0] cross_q [d];
    logic [d-1:0] blind_q [d];
    logic [d-1:0] inb_q;
    logic [d-1:0] inc_q;

    // Intentionally unreset: the scheduler only trusts the output when it has an op in flight.
    always_ff @(posedge clk) begin
        inb_q <= inb;
        inc_q <= inc;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i != j) begin
                    cross_q[i][j] <= ina[i] & (inb[j] ^ rnd[pair_idx(i, j)]);
                    blind_q[i][j] <= (~ina[i] & rnd[pair_idx(i, j)]) ^ rnd[NPAIR + pair_idx(i, j)];
                end else begin
                    cross_q[i][j] <= 1'b0;
                    blind_q[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < d; i++) begin
            out[i] = (ina_prev[i] & inb_q[i]) ^ inc_q[i] ^ (^cross_q[i]) ^ (^blind_q[i]);
        end
    end

endmodule

// File: rtl/msk_sched_fifo2.sv
// Two-entry first-word-fall-through FIFO; the head reads as zero while empty.
module msk_sched_fifo2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is left unreset; the count gates visibility, so reset only clears the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = (count_q != 2'd0) ? mem[rd_ptr] : '0;
    assign count    = count_q;

endmodule

// File: rtl/msk_tof_scheduler.sv
// Round-robin scheduler sharing one masked a&b^c gadget between NREQ requesters,
// with credit-based admission into a 2-entry result FIFO since the gadget cannot stall.
module msk_tof_scheduler
    import msk_sched_pkg::*;
#(
    parameter  int d       = 2,
    parameter  int NREQ    = 3,
    localparam int HPC3RND = hpc3_rnd_bits(d),
    localparam int TAGW    = tag_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*d-1:0]    req_a,
    input  logic [NREQ*d-1:0]    req_b,
    input  logic [NREQ*d-1:0]    req_c,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [HPC3RND-1:0]   rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [d-1:0]         out_data,
    output logic [TAGW-1:0]      out_tag
);

    logic [TAGW-1:0]    rr_ptr;
    logic [TAGW-1:0]    grant_idx;
    logic [TAGW-1:0]    tag_q;
    logic [NREQ-1:0]    grant_onehot;
    logic               grant_found;
    logic               issue;
    logic               pop;
    logic               inflight;
    logic [1:0]         fifo_count;
    logic [1:0]         occ;
    logic [d-1:0]       gad_ina;
    logic [d-1:0]       gad_inb;
    logic [d-1:0]       gad_inc;
    logic [d-1:0]       ina_prev;
    logic [d-1:0]       gad_out;
    logic [HPC3RND-1:0] gad_rnd;
    logic [TAGW+d-1:0]  fifo_head;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_found  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[rr_index(int'(rr_ptr), k, NREQ)]) begin
                grant_found = 1'b1;
                grant_idx   = TAGW'(rr_index(int'(rr_ptr), k, NREQ));
                grant_onehot[rr_index(int'(rr_ptr), k, NREQ)] = 1'b1;
            end
        end
    end

    // A pop in the same cycle frees the slot this issue will eventually land in.
    assign pop   = out_valid & out_ready;
    assign occ   = fifo_count + {1'b0, inflight};
    assign issue = rst_n & rnd_valid & grant_found & ((occ < 2'd2) | pop);

    assign req_ready = issue ? grant_onehot : '0;
    assign rnd_ready = issue;

    // Idle cycles drive zeros so stale shares never meet the gadget's cross terms.
    always_comb begin
        gad_ina = '0;
        gad_inb = '0;
        gad_inc = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (issue && grant_onehot[k]) begin
                gad_ina = gad_ina | req_a[k*d +: d];
                gad_inb = gad_inb | req_b[k*d +: d];
                gad_inc = gad_inc | req_c[k*d +: d];
            end
        end
        gad_rnd = issue ? rnd : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            tag_q    <= '0;
            inflight <= 1'b0;
            ina_prev <= '0;
        end else begin
            ina_prev <= gad_ina;
            inflight <= issue;
            if (issue) begin
                tag_q  <= grant_idx;
                rr_ptr <= TAGW'(rr_next(int'(grant_idx), NREQ));
            end
        end
    end

    MSKand_hpc3o_tof #(
        .d (d)
    ) u_gadget (
        .clk      (clk),
        .ina      (gad_ina),
        .inb      (gad_inb),
        .inc      (gad_inc),
        .ina_prev (ina_prev),
        .rnd      (gad_rnd),
        .out      (gad_out)
    );

    msk_sched_fifo2 #(
        .W (TAGW + d)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({tag_q, gad_out}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    assign out_valid           = (fifo_count != 2'd0);
    assign {out_tag, out_data} = fifo_head;

endmodule

// File: tb/tb_msk_tof_scheduler.sv
// Directed self-checking bench for msk_tof_scheduler with d=2, NREQ=3.
module tb_msk_tof_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [5:0] req_a;
    logic [5:0] req_b;
    logic [5:0] req_c;
    logic       rnd_valid;
    logic       rnd_ready;
    logic [1:0] rnd;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic [1:0] out_tag;

    int checks = 0;
    int errors = 0;
    int overflow_events = 0;

    // Unmasked operands held by each requester in the multi-requester tests.
    bit rr_a [3] = '{1'b1, 1'b1, 1'b0};
    bit rr_b [3] = '{1'b1, 1'b0, 1'b1};
    bit rr_c [3] = '{1'b0, 1'b0, 1'b1};
    bit rr_res [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    msk_tof_scheduler #(.d(2), .NREQ(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always @(posedge clk) begin
        if (rst_n && dut.fifo_count == 2'd2 && dut.inflight && !(out_valid && out_ready))
            overflow_events++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input int k, input bit a, input bit b, input bit c);
        bit sa, sb, sc;
        sa = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        sc = 1'($urandom_range(0, 1));
        req_a[k*2 +: 2] = {sa ^ a, sa};
        req_b[k*2 +: 2] = {sb ^ b, sb};
        req_c[k*2 +: 2] = {sc ^ c, sc};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
        rnd_valid = 1'b0; rnd = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 3'b111; rnd_valid = 1'b1; out_ready = 1'b1;
        req_a = 6'h3f; req_b = 6'h3f; req_c = 6'h15; rnd = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
        checks++; if (rnd_ready !== 1'b0) begin errors++; $display("FAIL reset_rnd_ready: got %b expected 0", rnd_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 2'b00) begin errors++; $display("FAIL reset_out_data: got %b expected 00", out_data); end
        checks++; if (out_tag !== 2'b00) begin errors++; $display("FAIL reset_out_tag: got %b expected 00", out_tag); end
    endtask

    task automatic test_single_op();
        for (int p = 0; p < 4; p++) begin
            do_reset();
            @(negedge clk);
            req_valid = 3'b010;
            req_a[3:2] = 2'b01; req_b[3:2] = 2'b10; req_c[3:2] = 2'b11;
            rnd = 2'(p); rnd_valid = 1'b1; out_ready = 1'b1;
            #1;
            checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_grant p=%0d: got %b expected 010", p, req_ready); end
            checks++; if (rnd_ready !== 1'b1) begin errors++; $display("FAIL single_rnd_ready p=%0d: got %b expected 1", p, rnd_ready); end
            @(negedge clk);
            req_valid = 3'b000; rnd_valid = 1'b0; #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid p=%0d: got %b expected 0", p, out_valid); end
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b1 || out_tag !== 2'd1) begin errors++; $display("FAIL single_out p=%0d: valid=%b tag=%0d expected valid=1 tag=1", p, out_valid, out_tag); end
            checks++; if ((^out_data) !== 1'b1) begin errors++; $display("FAIL single_result p=%0d: got %b expected 1", p, ^out_data); end
            @(negedge clk); #1;
            checks++; if (out_valid !== 1'b0 || out_data !== 2'b00) begin errors++; $display("FAIL single_drain p=%0d: valid=%b data=%b expected 0/00", p, out_valid, out_data); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 3; k++) set_req(k, rr_a[k], rr_b[k], rr_c[k]);
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            req_valid = (n < 8) ? 3'b111 : 3'b000;
            rnd_valid = 1'b1;
            rnd = 2'($urandom_range(0, 3));
            #1;
            if (n < 8) begin
                checks++; if (req_ready !== 3'(1 << (n % 3))) begin errors++; $display("FAIL rr_grant n=%0d: got %b expected %b", n, req_ready, 3'(1 << (n % 3))); end
            end
            if (n >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 2'((n - 2) % 3) || (^out_data) !== rr_res[(n - 2) % 3]) begin
                    errors++;
                    $display("FAIL rr_out n=%0d: valid=%b tag=%0d res=%b expected 1 tag=%0d res=%b", n, out_valid, out_tag, ^out_data, (n - 2) % 3, rr_res[(n - 2) % 3]);
                end
            end
        end
        rnd_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_grant [12] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
                                       3'b100, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000};
        bit         exp_ov [12]    = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int         exp_tag [12]   = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0};
        do_reset();
        for (int k = 0; k < 3; k++) set_req(k, rr_a[k], rr_b[k], rr_c[k]);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            req_valid = (n < 9) ? 3'b111 : 3'b000;
            out_ready = (n >= 6);
            rnd_valid = 1'b1;
            rnd = 2'($urandom_range(0, 3));
            #1;
            checks++; if (req_ready !== exp_grant[n]) begin errors++; $display("FAIL bp_grant n=%0d: got %b expected %b", n, req_ready, exp_grant[n]); end
            checks++; if (out_valid !== exp_ov[n]) begin errors++; $display("FAIL bp_valid n=%0d: got %b expected %b", n, out_valid, exp_ov[n]); end
            if (exp_ov[n]) begin
                checks++;
                if (out_tag !== 2'(exp_tag[n]) || (^out_data) !== rr_res[exp_tag[n]]) begin
                    errors++;
                    $display("FAIL bp_out n=%0d: tag=%0d res=%b expected tag=%0d res=%b", n, out_tag, ^out_data, exp_tag[n], rr_res[exp_tag[n]]);
                end
            end
        end
        rnd_valid = 1'b0;
    endtask

    task automatic test_prng_starvation();
        do_reset();
        for (int k = 0; k < 3; k++) set_req(k, rr_a[k], rr_b[k], rr_c[k]);
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            req_valid = (n < 7) ? 3'b111 : 3'b000;
            rnd_valid = (n == 0 || n == 6);
            rnd = 2'b11;
            #1;
            if (n == 0) begin
                checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL starve_first_grant: got %b expected 001", req_ready); end
            end else if (n <= 5) begin
                checks++; if (req_ready !== 3'b000 || rnd_ready !== 1'b0) begin errors++; $display("FAIL starve_hold n=%0d: req_ready=%b rnd_ready=%b expected 000/0", n, req_ready, rnd_ready); end
                checks++;
                if ({dut.gad_ina, dut.gad_inb, dut.gad_inc, dut.gad_rnd} !== 8'h00) begin
                    errors++;
                    $display("FAIL starve_gadget_zero n=%0d: got %h expected 00", n, {dut.gad_ina, dut.gad_inb, dut.gad_inc, dut.gad_rnd});
                end
            end else if (n == 6) begin
                checks++; if (req_ready !== 3'b010 || rnd_ready !== 1'b1) begin errors++; $display("FAIL starve_resume: req_ready=%b rnd_ready=%b expected 010/1", req_ready, rnd_ready); end
            end
            if (n == 2) begin
                checks++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || (^out_data) !== rr_res[0]) begin errors++; $display("FAIL starve_out0: valid=%b tag=%0d res=%b expected 1/0/%b", out_valid, out_tag, ^out_data, rr_res[0]); end
            end
            if (n == 8) begin
                checks++; if (out_valid !== 1'b1 || out_tag !== 2'd1 || (^out_data) !== rr_res[1]) begin errors++; $display("FAIL starve_out1: valid=%b tag=%0d res=%b expected 1/1/%b", out_valid, out_tag, ^out_data, rr_res[1]); end
            end
        end
    endtask

    task automatic test_truth_table();
        bit tt_exp [8];
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n < 8) begin
                bit a, b, c;
                a = n[2]; b = n[1]; c = n[0];
                tt_exp[n] = (a & b) ^ c;
                set_req(0, a, b, c);
                req_valid = 3'b001;
                rnd_valid = 1'b1;
                rnd = 2'($urandom_range(0, 3));
            end else begin
                req_valid = 3'b000;
                rnd_valid = 1'b0;
            end
            #1;
            if (n >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 2'd0 || (^out_data) !== tt_exp[n - 2]) begin
                    errors++;
                    $display("FAIL truth abc=%0d: valid=%b tag=%0d res=%b expected 1/0/%b", n - 2, out_valid, out_tag, ^out_data, tt_exp[n - 2]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b0);
        set_req(1, 1'b0, 1'b0, 1'b0);
        set_req(2, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        req_valid = 3'b001; rnd_valid = 1'b1; rnd = 2'b01; #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL midreset_first_grant: got %b expected 001", req_ready); end
        @(negedge clk);
        req_valid = 3'b111; rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 2'b00 || out_tag !== 2'b00) begin errors++; $display("FAIL midreset_outputs: valid=%b data=%b tag=%b expected 0/00/00", out_valid, out_data, out_tag); end
        checks++; if (req_ready !== 3'b000 || rnd_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: req_ready=%b rnd_ready=%b expected 000/0", req_ready, rnd_ready); end
        @(negedge clk);
        rst_n = 1'b1; req_valid = 3'b000; rnd_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_stale: got valid %b expected 0", out_valid); end
        @(negedge clk);
        req_valid = 3'b011; rnd_valid = 1'b1; rnd = 2'b10; #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL midreset_ptr: got %b expected 001", req_ready); end
        @(negedge clk);
        req_valid = 3'b000; rnd_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || (^out_data) !== 1'b1) begin errors++; $display("FAIL midreset_result: valid=%b tag=%0d res=%b expected 1/0/1", out_valid, out_tag, ^out_data); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_prng_starvation();
        test_truth_table();
        test_reset_midflight();
        checks++;
        if (overflow_events != 0) begin
            errors++;
            $display("FAIL fifo_overflow: got %0d push-at-full events expected 0", overflow_events);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
